// File: rtl/fetch_dec_buf.sv
// fetch_dec_buf: circular instruction buffer between fetch and decode.
//   Fetch side : f_valid/f_pc/f_inst/f_pred (FETCH_WIDTH lanes, lane 0 in LSBs),
//                f_ready = room for a full fetch group. Valid lanes are compacted.
//   Decode side: d_valid/d_pc/d_inst/d_pred show the oldest DEC_WIDTH entries
//                (first-word-fall-through); d_take pops a lane-0-anchored prefix.
//   Status     : count = occupied entries, err = sticky take-on-invalid flag.
//   Control    : flush discards all entries; reset_ is async active-low.
module fetch_dec_buf #(
  parameter int ADDR        = 32,
  parameter int INST        = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int DEC_WIDTH   = 2,
  parameter int DEPTH       = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset_,
  input  logic                        flush,
  input  logic [FETCH_WIDTH-1:0]      f_valid,
  input  logic [FETCH_WIDTH*ADDR-1:0] f_pc,
  input  logic [FETCH_WIDTH*INST-1:0] f_inst,
  input  logic [FETCH_WIDTH-1:0]      f_pred,
  output logic                        f_ready,
  output logic [DEC_WIDTH-1:0]        d_valid,
  output logic [DEC_WIDTH*ADDR-1:0]   d_pc,
  output logic [DEC_WIDTH*INST-1:0]   d_inst,
  output logic [DEC_WIDTH-1:0]        d_pred,
  input  logic [DEC_WIDTH-1:0]        d_take,
  output logic [CW-1:0]               count,
  output logic                        err
);

  // Entry storage: no reset, contents only meaningful below count.
  logic [ADDR-1:0] pc_mem   [DEPTH];
  logic [INST-1:0] inst_mem [DEPTH];
  logic            pred_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;

  logic [FETCH_WIDTH-1:0][AW-1:0] wslot;
  logic [CW-1:0]                  push_n, pop_n;
  logic                           push_en, run;

  // Ready from the registered count only, so a slot popped this cycle is not
  // offered to fetch until the following cycle.
  assign f_ready = (32'(count_q) + 32'(FETCH_WIDTH)) <= 32'(DEPTH);
  assign push_en = f_ready & ~flush;
  assign count   = count_q;
  assign err     = err_q;

  always_comb begin
    // Compaction: each valid lane lands at wr_ptr + (valid lanes below it).
    push_n = '0;
    wslot  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      wslot[i] = wr_ptr_q[AW-1:0] + AW'(push_n);
      push_n   = push_n + CW'(f_valid[i]);
    end
    // Pop the unbroken run of taken, valid lanes starting at lane 0.
    pop_n = '0;
    run   = 1'b1;
    for (int i = 0; i < DEC_WIDTH; i++) begin
      run   = run & d_take[i] & d_valid[i];
      pop_n = pop_n + CW'(run);
    end
  end

  always_comb begin
    err_d = err_q | (|(d_take & ~d_valid));
    if (flush) begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + (push_en ? PW'(push_n) : PW'(0));
      rd_ptr_d = rd_ptr_q + PW'(pop_n);
      count_d  = count_q + (push_en ? push_n : CW'(0)) - pop_n;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
        if (f_valid[i]) begin
          pc_mem[wslot[i]]   <= f_pc[i*ADDR +: ADDR];
          inst_mem[wslot[i]] <= f_inst[i*INST +: INST];
          pred_mem[wslot[i]] <= f_pred[i];
        end
      end
    end
  end

  // Decode lanes read consecutive slots from the head, wrapping mod DEPTH.
  for (genvar g = 0; g < DEC_WIDTH; g++) begin : g_dec
    logic [AW-1:0] rslot;
    assign rslot                  = rd_ptr_q[AW-1:0] + AW'(g);
    assign d_valid[g]             = CW'(g) < count_q;
    assign d_pc[g*ADDR +: ADDR]   = pc_mem[rslot];
    assign d_inst[g*INST +: INST] = inst_mem[rslot];
    assign d_pred[g]              = pred_mem[rslot];
  end

endmodule

// File: tb/tb_fetch_dec_buf.sv
module tb_fetch_dec_buf;
  localparam int ADDR = 32, INST = 32, FW = 2, DW = 2, DEPTH = 8;

  logic            clk = 1'b0, reset_ = 1'b0, flush = 1'b0;
  logic [FW-1:0]   f_valid = '0, f_pred = '0;
  logic [FW*ADDR-1:0] f_pc = '0;
  logic [FW*INST-1:0] f_inst = '0;
  logic            f_ready;
  logic [DW-1:0]   d_valid, d_pred, d_take = '0;
  logic [DW*ADDR-1:0] d_pc;
  logic [DW*INST-1:0] d_inst;
  logic [3:0]      count;
  logic            err;

  fetch_dec_buf #(.ADDR(ADDR), .INST(INST), .FETCH_WIDTH(FW), .DEC_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_(reset_), .flush(flush), .f_valid(f_valid), .f_pc(f_pc),
    .f_inst(f_inst), .f_pred(f_pred), .f_ready(f_ready), .d_valid(d_valid),
    .d_pc(d_pc), .d_inst(d_inst), .d_pred(d_pred), .d_take(d_take),
    .count(count), .err(err));

  always #5 clk = ~clk;

  typedef struct { logic [ADDR-1:0] pc; logic [INST-1:0] inst; logic pred; } ent_t;
  typedef struct {
    logic [1:0] fv; logic [1:0] take; logic fl;
    int exp_count; logic [1:0] exp_dv; logic exp_fr; logic exp_err;
  } vec_t;

  ent_t sbq[$];
  int   n_chk = 0, n_fail = 0;
  int   m_count = 0;
  logic [ADDR-1:0] base = 32'h1000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic [ADDR-1:0] pc);
    ent_t e;
    e.pc = pc; e.inst = pc ^ 32'hA5A5_0000; e.pred = pc[2];
    return e;
  endfunction

  // Called at a negedge: drive one cycle, check head data against the
  // scoreboard, clock, then update the scoreboard from the expected effects.
  task automatic step(input logic [1:0] fv, input logic [1:0] take, input logic fl);
    bit acc; int npop; bit run;
    ent_t e;
    f_valid = fv; d_take = take; flush = fl;
    for (int i = 0; i < FW; i++) begin
      e = mk(base + ADDR'(4*i));
      f_pc[i*ADDR +: ADDR] = e.pc; f_inst[i*INST +: INST] = e.inst; f_pred[i] = e.pred;
    end
    #1;
    for (int i = 0; i < DW; i++)
      if (i < m_count && i < sbq.size()) begin
        chk($sformatf("d_pc[%0d]", i), 64'(d_pc[i*ADDR +: ADDR]), 64'(sbq[i].pc));
        chk($sformatf("d_inst[%0d]", i), 64'(d_inst[i*INST +: INST]), 64'(sbq[i].inst));
        chk($sformatf("d_pred[%0d]", i), 64'(d_pred[i]), 64'(sbq[i].pred));
      end
    acc = !fl && (DEPTH - m_count) >= FW;
    npop = 0; run = 1;
    for (int i = 0; i < DW; i++) begin
      run = run && take[i] && (i < m_count);
      if (run) npop++;
    end
    @(posedge clk);
    if (fl) begin
      sbq.delete(); m_count = 0;
    end else begin
      for (int i = 0; i < npop; i++) void'(sbq.pop_front());
      if (acc) begin
        for (int i = 0; i < FW; i++) if (fv[i]) sbq.push_back(mk(base + ADDR'(4*i)));
        base = base + ADDR'(4*FW);
      end
      m_count = sbq.size();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    f_valid = 2'b11; d_take = '0; flush = 0;
    reset_ = 0;
    repeat (2) @(negedge clk);
    chk("rst count", 64'(count), 64'd0);
    chk("rst d_valid", 64'(d_valid), 64'd0);
    chk("rst f_ready", 64'(f_ready), 64'd1);
    chk("rst err", 64'(err), 64'd0);
    sbq.delete(); m_count = 0;
    reset_ = 1;
  endtask

  task automatic chk_out(input string tag, input int c, input logic [1:0] dv, input logic fr, input logic e);
    chk({tag, " count"}, 64'(count), 64'(c));
    chk({tag, " d_valid"}, 64'(d_valid), 64'(dv));
    chk({tag, " f_ready"}, 64'(f_ready), 64'(fr));
    chk({tag, " err"}, 64'(err), 64'(e));
  endtask

  vec_t vt[$];

  initial begin
    // {f_valid, d_take, flush, count, d_valid, f_ready, err} after the edge
    vt = '{
      '{2'b11, 2'b00, 1'b0, 2, 2'b11, 1'b1, 1'b0},   // fill
      '{2'b11, 2'b00, 1'b0, 4, 2'b11, 1'b1, 1'b0},
      '{2'b11, 2'b00, 1'b0, 6, 2'b11, 1'b1, 1'b0},
      '{2'b11, 2'b00, 1'b0, 8, 2'b11, 1'b0, 1'b0},
      '{2'b11, 2'b00, 1'b0, 8, 2'b11, 1'b0, 1'b0},   // full: group ignored
      '{2'b00, 2'b11, 1'b0, 6, 2'b11, 1'b1, 1'b0},
      '{2'b00, 2'b11, 1'b0, 4, 2'b11, 1'b1, 1'b0},
      '{2'b00, 2'b11, 1'b0, 2, 2'b11, 1'b1, 1'b0},
      '{2'b11, 2'b11, 1'b0, 2, 2'b11, 1'b1, 1'b0},   // push 2 / pop 2
      '{2'b10, 2'b01, 1'b0, 2, 2'b11, 1'b1, 1'b0},   // push 1 / pop 1
      '{2'b11, 2'b00, 1'b0, 4, 2'b11, 1'b1, 1'b0},
      '{2'b11, 2'b00, 1'b0, 6, 2'b11, 1'b1, 1'b0},
      '{2'b11, 2'b11, 1'b0, 6, 2'b11, 1'b1, 1'b0},   // simultaneous
      '{2'b11, 2'b10, 1'b0, 8, 2'b11, 1'b0, 1'b0},   // take 10 pops nothing
      '{2'b11, 2'b11, 1'b1, 0, 2'b00, 1'b1, 1'b0},   // flush wins
      '{2'b00, 2'b01, 1'b0, 0, 2'b00, 1'b1, 1'b1},   // take while empty
      '{2'b11, 2'b00, 1'b0, 2, 2'b11, 1'b1, 1'b1},   // err sticky
      '{2'b00, 2'b00, 1'b1, 0, 2'b00, 1'b1, 1'b1},   // flush keeps err
      '{2'b01, 2'b00, 1'b0, 1, 2'b01, 1'b1, 1'b1}
    };

    @(negedge clk);
    do_reset();
    foreach (vt[k]) begin
      step(vt[k].fv, vt[k].take, vt[k].fl);
      chk_out($sformatf("vec%0d", k), vt[k].exp_count, vt[k].exp_dv, vt[k].exp_fr, vt[k].exp_err);
    end

    // Async reset mid-operation: d_valid must fall without a clock edge.
    #2 reset_ = 0;
    #1;
    chk("async d_valid", 64'(d_valid), 64'd0);
    chk("async count", 64'(count), 64'd0);
    chk("async f_ready", 64'(f_ready), 64'd1);
    @(negedge clk);
    do_reset();

    // Compaction: only lane 1 valid.
    base = 32'h100;
    step(2'b10, 2'b00, 0);
    chk_out("compact", 1, 2'b01, 1'b1, 1'b0);
    chk("compact d_pc0", 64'(d_pc[31:0]), 64'h104);
    step(2'b00, 2'b01, 0);
    chk_out("compact drain", 0, 2'b00, 1'b1, 1'b0);

    // Wrap: push 6, take 2+2, push 4 -> slots straddle 7->0.
    @(negedge clk);
    do_reset();
    repeat (3) step(2'b11, 2'b00, 0);
    step(2'b00, 2'b11, 0);
    step(2'b00, 2'b11, 0);
    step(2'b11, 2'b00, 0);
    step(2'b11, 2'b00, 0);
    chk_out("wrap", 6, 2'b11, 1'b1, 1'b0);
    repeat (3) step(2'b00, 2'b11, 0);
    chk_out("wrap drain", 0, 2'b00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
